// File: rtl/mem_responder.sv
// Memory-side responder for the 16-bit CPU: decodes each single-word request to
// block RAM, memory-mapped I/O registers or unmapped space, one access at a time.
`timescale 1ns/1ps
module mem_responder #(
   parameter int          MEM_DEPTH  = 1024,
   parameter int          RD_LATENCY = 1,
   parameter logic [15:0] IO_BASE    = 16'hFF00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic [15:0] ram_addr,
   output logic [15:0] ram_wdata,
   output logic        ram_we,
   input  logic [15:0] ram_rdata,
   input  logic [9:0]  sw_in,
   output logic [15:0] led_out
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RAM_RD = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   localparam logic [16:0] MEM_LIMIT = 17'(MEM_DEPTH);
   localparam logic [2:0]  WAIT_INIT = 3'(RD_LATENCY);
   localparam logic [15:0] IO_LED    = IO_BASE;
   localparam logic [15:0] IO_SW     = IO_BASE + 16'd1;
   localparam logic [15:0] IO_CNT    = IO_BASE + 16'd2;

   logic [1:0]  state_r;
   logic [1:0]  next_state_s;
   logic [2:0]  wait_r;
   logic        rd_ram_r;
   logic [15:0] pend_rdata_r;
   logic        req_ready_r;
   logic        resp_valid_r;
   logic [15:0] resp_rdata_r;
   logic [15:0] ram_addr_r;
   logic [15:0] ram_wdata_r;
   logic        ram_we_r;
   logic [15:0] led_r;
   logic [15:0] cnt_r;
   logic        accept_s;
   logic        hit_ram_s;
   logic        hit_io_s;
   logic        led_load_s;
   logic        cnt_load_s;
   logic [15:0] io_rdata_s;

   assign req_ready  = req_ready_r;
   assign resp_valid = resp_valid_r;
   assign resp_rdata = resp_rdata_r;
   assign ram_addr   = ram_addr_r;
   assign ram_wdata  = ram_wdata_r;
   assign ram_we     = ram_we_r;
   assign led_out    = led_r;

   // Acceptance, address decode and I/O read mux; RAM wins if the windows overlap
   always_comb begin
      accept_s   = req_ready_r & req_valid & (state_r == IDLE);
      hit_ram_s  = ({1'b0, req_addr} < MEM_LIMIT);
      hit_io_s   = ~hit_ram_s & (req_addr >= IO_BASE);
      led_load_s = accept_s & hit_io_s & req_we & (req_addr == IO_LED);
      cnt_load_s = accept_s & hit_io_s & req_we & (req_addr == IO_CNT);
      if (hit_io_s && !req_we) begin
         if (req_addr == IO_LED) begin
            io_rdata_s = led_r;
         end else if (req_addr == IO_SW) begin
            io_rdata_s = {6'd0, sw_in};
         end else if (req_addr == IO_CNT) begin
            io_rdata_s = cnt_r;
         end else begin
            io_rdata_s = 16'd0;
         end
      end else begin
         io_rdata_s = 16'd0;
      end
   end

   // Next-state logic; RAM_RD with a zero wait count is the one-cycle turnaround
   // used by writes, I/O and unmapped accesses
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               next_state_s = RAM_RD;
            end else begin
               next_state_s = IDLE;
            end
         end
         RAM_RD: begin
            if (wait_r == 3'd0) begin
               next_state_s = RESP;
            end else begin
               next_state_s = RAM_RD;
            end
         end
         RESP:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Access sequencing, RAM port and response datapath
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r      <= IDLE;
         wait_r       <= 3'd0;
         rd_ram_r     <= 1'b0;
         pend_rdata_r <= 16'd0;
         req_ready_r  <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 16'd0;
         ram_addr_r   <= 16'd0;
         ram_wdata_r  <= 16'd0;
         ram_we_r     <= 1'b0;
      end else begin
         state_r      <= next_state_s;
         req_ready_r  <= (next_state_s == IDLE);
         resp_valid_r <= (next_state_s == RESP);
         ram_we_r     <= 1'b0;
         if (accept_s) begin
            wait_r       <= (hit_ram_s & ~req_we) ? WAIT_INIT : 3'd0;
            rd_ram_r     <= hit_ram_s & ~req_we;
            pend_rdata_r <= io_rdata_s;
            if (hit_ram_s) begin
               ram_addr_r <= req_addr;
               if (req_we) begin
                  ram_wdata_r <= req_wdata;
                  ram_we_r    <= 1'b1;
               end else begin
                  ram_wdata_r <= ram_wdata_r;
               end
            end else begin
               ram_addr_r <= ram_addr_r;
            end
         end else if ((state_r == RAM_RD) && (wait_r != 3'd0)) begin
            wait_r <= wait_r - 3'd1;
         end else begin
            wait_r <= wait_r;
         end
         // Response data only changes on entry to RESP, so it holds otherwise
         if ((state_r == RAM_RD) && (wait_r == 3'd0)) begin
            resp_rdata_r <= rd_ram_r ? ram_rdata : pend_rdata_r;
         end else begin
            resp_rdata_r <= resp_rdata_r;
         end
      end
   end

   // LED register and free-running cycle counter; a counter write beats the increment
   always_ff @(posedge clk) begin
      if (!reset) begin
         led_r <= 16'd0;
         cnt_r <= 16'd0;
      end else begin
         if (led_load_s) begin
            led_r <= req_wdata;
         end else begin
            led_r <= led_r;
         end
         if (cnt_load_s) begin
            cnt_r <= req_wdata;
         end else begin
            cnt_r <= cnt_r + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic scored against a transaction-level model of RAM, LED and counter.
`timescale 1ns/1ps
module tb_mem_responder;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset, reset3, req_valid, req_valid3, req_we;
   logic [15:0] req_addr, req_wdata;
   logic [9:0]  sw_in;
   logic        req_ready, resp_valid, ram_we;
   logic [15:0] resp_rdata, ram_addr, ram_wdata, ram_rdata, led_out;
   logic        req_ready3, resp_valid3, ram_we3;
   logic [15:0] resp_rdata3, ram_addr3, ram_wdata3, ram_rdata3, led_out3;

   logic        preload;
   logic [15:0] mem [DEPTH];
   logic [15:0] pipe1;
   logic [15:0] pipe3 [3];

   int          n_run = 0;
   int          n_fail = 0;
   int          edge_n = 0;

   logic [15:0] ref_mem [DEPTH];
   logic [15:0] model_led;
   logic [15:0] cnt_val;
   int          cnt_edge;

   int          o_acc, o_lat, o_nresp, o_nwe, o_we_off, o_rdy_low;
   logic [15:0] o_rdata, o_we_addr, o_we_data, o_led0;

   always #5 clk = ~clk;

   mem_responder #(.MEM_DEPTH(DEPTH), .RD_LATENCY(1), .IO_BASE(16'hFF00)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
      .sw_in(sw_in), .led_out(led_out));

   mem_responder #(.MEM_DEPTH(DEPTH), .RD_LATENCY(3), .IO_BASE(16'hFF00)) dut3 (
      .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready3),
      .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .ram_addr(ram_addr3),
      .ram_wdata(ram_wdata3), .ram_we(ram_we3), .ram_rdata(ram_rdata3),
      .sw_in(sw_in), .led_out(led_out3));

   function automatic logic [15:0] seed(input int i);
      return 16'(i * 40503) ^ 16'h5A5A;
   endfunction

   // Block RAM stand-in: latency-1 port for dut, latency-3 read-only port for dut3
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= seed(i);
      end else if (ram_we === 1'b1) begin
         mem[ram_addr[9:0]] <= ram_wdata;
      end
      pipe1    <= mem[ram_addr[9:0]];
      pipe3[0] <= mem[ram_addr3[9:0]];
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign ram_rdata  = pipe1;
   assign ram_rdata3 = pipe3[2];

   // Reference model: what a read accepted at edge k must return
   function automatic logic [15:0] model_read(input logic [15:0] a, input int k);
      if (a < 16'd1024)       return ref_mem[a[9:0]];
      else if (a == 16'hFF00) return model_led;
      else if (a == 16'hFF01) return {6'd0, sw_in};
      else if (a == 16'hFF02) return cnt_val + 16'(k - 1 - cnt_edge);
      else                    return 16'd0;
   endfunction

   task automatic model_write(input logic [15:0] a, input logic [15:0] d, input int k);
      if (a < 16'd1024)       ref_mem[a[9:0]] = d;
      else if (a == 16'hFF00) model_led = d;
      else if (a == 16'hFF02) begin cnt_val = d; cnt_edge = k; end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   // Issues one request to dut and records what happens over the next 8 edges
   task automatic drive(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
      req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      tick();
      o_acc = edge_n;
      req_valid = 1'b0;
      req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
      sw_in = 10'($urandom);
      o_lat = -1; o_nresp = 0; o_nwe = 0; o_we_off = -1; o_rdy_low = 0;
      o_rdata = 16'hDEAD; o_we_addr = 16'd0; o_we_data = 16'd0; o_led0 = led_out;
      for (int off = 0; off < 8; off++) begin
         if (off > 0) tick();
         if (resp_valid === 1'b1) begin
            o_nresp++;
            if (o_lat < 0) begin o_lat = off; o_rdata = resp_rdata; end
         end
         if (ram_we === 1'b1) begin
            o_nwe++;
            if (o_we_off < 0) begin o_we_off = off; o_we_addr = ram_addr; o_we_data = ram_wdata; end
         end
         if (req_ready !== 1'b1) o_rdy_low++;
      end
   endtask

   task automatic pick(output logic w, output logic [15:0] a, output logic [15:0] d);
      int sel;
      logic [15:0] edges [4];
      edges[0] = 16'd1023; edges[1] = 16'd1024; edges[2] = 16'hFEFF; edges[3] = 16'hFF00;
      sel = $urandom_range(0, 4);
      w = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      case (sel)
         0, 1:    a = 16'($urandom_range(0, 1023));
         2:       a = 16'hFF00 + 16'($urandom_range(0, 5));
         3:       a = 16'($urandom_range(1024, 16'hFEFF));
         default: a = edges[$urandom_range(0, 3)];
      endcase
   endtask

   task automatic test_reset();
      reset = 1'b0; reset3 = 1'b0; preload = 1'b1;
      tick();
      preload = 1'b0;
      tick();
      n_run++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
      n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
      n_run++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
      n_run++; if (resp_rdata !== 16'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", resp_rdata); end
      n_run++; if (ram_addr !== 16'd0 || ram_wdata !== 16'd0) begin n_fail++; $display("FAIL reset_ram_port: got %h/%h want 0000/0000", ram_addr, ram_wdata); end
      n_run++; if (led_out !== 16'd0) begin n_fail++; $display("FAIL reset_led: got %h want 0000", led_out); end
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed(i);
      model_led = 16'd0; cnt_val = 16'd0; cnt_edge = edge_n;
      reset = 1'b1; reset3 = 1'b1;
      tick();
      n_run++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", req_ready); end
      n_run++; if (req_ready3 !== 1'b1) begin n_fail++; $display("FAIL reset_ready3_after: got %b want 1", req_ready3); end
   endtask

   task automatic test_led_write();
      drive(1'b1, 16'hFF00, 16'hA5A5);
      model_write(16'hFF00, 16'hA5A5, o_acc);
      n_run++; if (o_led0 !== 16'hA5A5) begin n_fail++; $display("FAIL led_write: got %h want a5a5", o_led0); end
      n_run++; if (o_nresp != 1 || o_lat != 1) begin n_fail++; $display("FAIL led_resp: got %0d pulses at %0d want 1 at 1", o_nresp, o_lat); end
      n_run++; if (o_rdata !== 16'd0) begin n_fail++; $display("FAIL led_rdata: got %h want 0000", o_rdata); end
      n_run++; if (o_nwe != 0) begin n_fail++; $display("FAIL led_ram_we: got %0d want 0", o_nwe); end
      n_run++; if (o_rdy_low != 2) begin n_fail++; $display("FAIL led_ready: got %0d busy cycles want 2", o_rdy_low); end
   endtask

   task automatic test_ram_rw();
      drive(1'b1, 16'h0010, 16'h1234);
      model_write(16'h0010, 16'h1234, o_acc);
      n_run++; if (o_nwe != 1 || o_we_off != 0) begin n_fail++; $display("FAIL ram_we_pulse: got %0d at %0d want 1 at 0", o_nwe, o_we_off); end
      n_run++; if (o_we_addr !== 16'h0010 || o_we_data !== 16'h1234) begin n_fail++; $display("FAIL ram_we_port: got %h/%h want 0010/1234", o_we_addr, o_we_data); end
      n_run++; if (o_lat != 1 || o_rdata !== 16'd0) begin n_fail++; $display("FAIL ram_wr_resp: got %h at %0d want 0000 at 1", o_rdata, o_lat); end
      drive(1'b0, 16'h0010, 16'h0000);
      n_run++; if (o_lat != 2 || o_nresp != 1) begin n_fail++; $display("FAIL ram_rd_lat: got %0d pulses at %0d want 1 at 2", o_nresp, o_lat); end
      n_run++; if (o_rdata !== 16'h1234) begin n_fail++; $display("FAIL ram_rd_data: got %h want 1234", o_rdata); end
      n_run++; if (o_rdy_low != 3) begin n_fail++; $display("FAIL ram_rd_ready: got %0d busy cycles want 3", o_rdy_low); end
   endtask

   task automatic test_sw_unmapped();
      sw_in = 10'h3FF;
      drive(1'b0, 16'hFF01, 16'h0000);
      n_run++; if (o_rdata !== 16'h03FF || o_lat != 1) begin n_fail++; $display("FAIL sw_read: got %h at %0d want 03ff at 1", o_rdata, o_lat); end
      drive(1'b0, 16'h0400, 16'h0000);
      n_run++; if (o_rdata !== 16'h0000 || o_lat != 1) begin n_fail++; $display("FAIL unmapped_read: got %h at %0d want 0000 at 1", o_rdata, o_lat); end
      drive(1'b1, 16'h0400, 16'hBEEF);
      n_run++; if (o_nwe != 0 || o_nresp != 1) begin n_fail++; $display("FAIL unmapped_write: got we=%0d resp=%0d want 0/1", o_nwe, o_nresp); end
   endtask

   task automatic test_counter();
      logic [15:0] exp;
      drive(1'b1, 16'hFF02, 16'hFFFE);
      model_write(16'hFF02, 16'hFFFE, o_acc);
      tick();
      tick();
      exp = model_read(16'hFF02, edge_n + 1);
      drive(1'b0, 16'hFF02, 16'h0000);
      n_run++; if (o_rdata !== exp) begin n_fail++; $display("FAIL counter_wrap: got %h want %h", o_rdata, exp); end
      exp = model_read(16'hFF02, edge_n + 1);
      drive(1'b0, 16'hFF02, 16'h0000);
      n_run++; if (o_rdata !== exp) begin n_fail++; $display("FAIL counter_run: got %h want %h", o_rdata, exp); end
   endtask

   task automatic test_random();
      logic w;
      logic [15:0] a, d, exp;
      int exp_lat;
      for (int t = 0; t < 40; t++) begin
         pick(w, a, d);
         exp     = w ? 16'd0 : model_read(a, edge_n + 1);
         exp_lat = (!w && a < 16'd1024) ? 2 : 1;
         drive(w, a, d);
         if (w) model_write(a, d, o_acc);
         n_run++; if (o_lat != exp_lat || o_nresp != 1) begin n_fail++; $display("FAIL rand_resp[%0d]: addr %h got %0d pulses at %0d want 1 at %0d", t, a, o_nresp, o_lat, exp_lat); end
         n_run++; if (o_rdata !== exp) begin n_fail++; $display("FAIL rand_rdata[%0d]: addr %h we %b got %h want %h", t, a, w, o_rdata, exp); end
         n_run++; if (o_nwe != ((w && a < 16'd1024) ? 1 : 0)) begin n_fail++; $display("FAIL rand_ram_we[%0d]: addr %h got %0d pulses", t, a, o_nwe); end
         n_run++; if (o_led0 !== model_led) begin n_fail++; $display("FAIL rand_led[%0d]: got %h want %h", t, o_led0, model_led); end
         n_run++; if (o_rdy_low != exp_lat + 1) begin n_fail++; $display("FAIL rand_ready[%0d]: got %0d busy cycles want %0d", t, o_rdy_low, exp_lat + 1); end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] q_data [$];
      int          q_edge [$];
      logic        w;
      logic [15:0] a, d, exp_d, got_d;
      int          idx, nresp, next_acc, exp_lat, got_e;
      idx = 0; nresp = 0; exp_d = 16'd0; exp_lat = 1;
      pick(w, a, d);
      req_we = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
      next_acc = edge_n + 1;
      for (int c = 0; c < 200 && (idx < 12 || q_data.size() > 0); c++) begin
         if (idx < 12) begin
            n_run++; if (req_ready !== (edge_n + 1 == next_acc)) begin n_fail++; $display("FAIL b2b_ready: edge %0d got %b want %b", edge_n, req_ready, (edge_n + 1 == next_acc)); end
            if (edge_n + 1 == next_acc) begin
               exp_d   = w ? 16'd0 : model_read(a, next_acc);
               exp_lat = (!w && a < 16'd1024) ? 2 : 1;
            end
         end
         tick();
         if (idx < 12 && edge_n == next_acc) begin
            q_data.push_back(exp_d);
            q_edge.push_back(edge_n + exp_lat);
            if (w) model_write(a, d, edge_n);
            next_acc = edge_n + exp_lat + 2;
            idx++;
            if (idx < 12) begin
               pick(w, a, d);
               req_we = w; req_addr = a; req_wdata = d;
            end else begin
               req_valid = 1'b0;
            end
         end
         if (resp_valid === 1'b1) begin
            nresp++;
            if (q_data.size() == 0) begin
               n_run++; n_fail++; $display("FAIL b2b_extra_resp: edge %0d got 1 want 0", edge_n);
            end else begin
               got_d = q_data.pop_front();
               got_e = q_edge.pop_front();
               n_run++; if (got_e != edge_n || resp_rdata !== got_d) begin n_fail++; $display("FAIL b2b_resp: got %h at edge %0d want %h at edge %0d", resp_rdata, edge_n, got_d, got_e); end
            end
         end
      end
      req_valid = 1'b0;
      n_run++; if (nresp != 12 || q_data.size() != 0) begin n_fail++; $display("FAIL b2b_count: got %0d responses want 12", nresp); end
   endtask

   task automatic test_reset_mid_read();
      logic [15:0] a;
      int seen, lat;
      logic [15:0] got;
      a = 16'($urandom_range(0, 1023));
      req_we = 1'b0; req_addr = a; req_valid3 = 1'b1;
      tick();
      req_valid3 = 1'b0; reset3 = 1'b0;
      tick();
      reset3 = 1'b1;
      n_run++; if (req_ready3 !== 1'b0 || ram_we3 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_state: got ready %b we %b want 0/0", req_ready3, ram_we3); end
      seen = (resp_valid3 === 1'b1) ? 1 : 0;
      tick();
      n_run++; if (req_ready3 !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 1", req_ready3); end
      for (int i = 0; i < 6; i++) begin
         if (resp_valid3 === 1'b1) seen++;
         tick();
      end
      n_run++; if (seen != 0) begin n_fail++; $display("FAIL mid_reset_no_resp: got %0d responses want 0", seen); end
      req_addr = a; req_valid3 = 1'b1;
      tick();
      req_valid3 = 1'b0;
      lat = -1; got = 16'hDEAD;
      for (int off = 0; off < 10; off++) begin
         if (off > 0) tick();
         if (resp_valid3 === 1'b1 && lat < 0) begin lat = off; got = resp_rdata3; end
      end
      n_run++; if (lat != 4 || got !== ref_mem[a[9:0]]) begin n_fail++; $display("FAIL lat3_read: got %h at %0d want %h at 4", got, lat, ref_mem[a[9:0]]); end
   endtask

   initial begin
      reset = 1'b0; reset3 = 1'b0; preload = 1'b0;
      req_valid = 1'b0; req_valid3 = 1'b0; req_we = 1'b0;
      req_addr = 16'd0; req_wdata = 16'd0; sw_in = 10'd0;
      test_reset();
      test_led_write();
      test_ram_rw();
      test_sw_unmapped();
      test_counter();
      test_random();
      test_back_to_back();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
